// File: rtl/mul_stream_ctrl_pkg.sv
// mul_stream_ctrl_pkg
//   Shared definitions for the multiplier front-end: the state encoding and
//   the data width that the multiplier and the ALU top must agree on.
//   Contents:
//     ALU_DATA_WIDTH  operand/result width used across the ALU (12)
//     ALU_CNT_WIDTH   default width of the completed-result counter (8)
//     state_e         LOAD_A=0, LOAD_B=1, EXEC=2, OUT=3
package mul_stream_ctrl_pkg;

  localparam int ALU_DATA_WIDTH = 12;
  localparam int ALU_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    OUT    = 2'd3
  } state_e;

endpackage

// File: rtl/mul_stream_ctrl.sv
// mul_stream_ctrl
//   Sequential front-end for the ALU multiplier stage. Pairs consecutive
//   words from the input stream into operands op_a/op_b, lets the external
//   combinational multiplier settle for one cycle (EXEC), captures its
//   product op_c and offers it on the output stream.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both high. The producer holds data stable while valid is high
//   and ready is low; this block holds out_data/out_valid stable until the
//   consumer raises out_ready.
//
//   Ports:
//     clk, rst_n      clock (rising edge), asynchronous active-low reset
//     clear           synchronous abort: back to LOAD_A, drops the pending
//                     result and zeroes result_count (operand/result
//                     registers keep their values)
//     in_data/valid/ready    operand word stream (A then B)
//     op_a, op_b      registered operands driven into the multiplier
//     op_c            product from the multiplier (mod 2^DATA_WIDTH)
//     out_data/valid/ready   product stream
//     busy            high whenever the FSM is not in LOAD_A
//     result_count    delivered results, wraps modulo 2^CNT_WIDTH
module mul_stream_ctrl
  import mul_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int CNT_WIDTH  = ALU_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  input  logic [DATA_WIDTH-1:0] op_c,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  result_count
);

  state_e state;

  // Ready and busy are pure decodes of the state register, so the input
  // stream sees back-pressure in the same cycle the FSM leaves LOAD_B.
  assign in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign busy     = (state != LOAD_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD_A;
      op_a         <= '0;
      op_b         <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      result_count <= '0;
    end else if (clear) begin
      // Abort wins over any handshake in the same cycle; a word offered
      // alongside clear is dropped and a pending result is not counted.
      state        <= LOAD_A;
      out_valid    <= 1'b0;
      result_count <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_valid) begin
            op_a  <= in_data;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            op_b  <= in_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          // op_a/op_b have been stable for a full cycle here, so the
          // multiplier output is settled.
          out_data  <= op_c;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            result_count <= result_count + 1'b1;
            state        <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_stream_ctrl.sv
// tb_mul_stream_ctrl
//   Directed bench for mul_stream_ctrl. A behavioural multiplier closes the
//   op_a/op_b -> op_c loop. Products are checked against a table of
//   hand-computed values, followed by hand-written sequences for
//   back-pressure, clear, asynchronous reset and counter wrap/throughput.
module tb_mul_stream_ctrl;

  localparam int DW = 12;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] op_c;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic [CW-1:0] result_count;

  int checks = 0;
  int errors = 0;

  mul_stream_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_c         (op_c),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .result_count (result_count)
  );

  // Stand-in for the ALU's combinational multiplier (truncating).
  logic [2*DW-1:0] prod;
  assign prod = op_a * op_b;
  assign op_c = prod[DW-1:0];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_c;
  } vec_t;

  vec_t vecs[6];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one word and return #1 after the edge that consumed it.
  task automatic send_word(input logic [DW-1:0] w);
    int t;
    in_data  = w;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called right after the B handshake; lat counts cycles from the handshake
  // cycle to the first cycle out_valid is seen (expected 2).
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // ---------------- stimulus / scoreboard ----------------
  initial begin
    int lat;
    int n;
    int prev_cyc;
    int cyc;
    logic [CW-1:0] prev_cnt;

    vecs[0] = '{a: 12'd5,    b: 12'd7,    exp_c: 12'd35};
    vecs[1] = '{a: 12'd100,  b: 12'd100,  exp_c: 12'd1808};
    vecs[2] = '{a: 12'd4095, b: 12'd4095, exp_c: 12'd1};
    vecs[3] = '{a: 12'd64,   b: 12'd64,   exp_c: 12'd0};
    vecs[4] = '{a: 12'd0,    b: 12'd123,  exp_c: 12'd0};
    vecs[5] = '{a: 12'd45,   b: 12'd91,   exp_c: 12'd4095};

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),     32'd1);
    check("rst_busy",      32'(busy),         32'd0);
    check("rst_out_valid", 32'(out_valid),    32'd0);
    check("rst_out_data",  32'(out_data),     32'd0);
    check("rst_op_a",      32'(op_a),         32'd0);
    check("rst_op_b",      32'(op_b),         32'd0);
    check("rst_count",     32'(result_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven products with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_word(vecs[i].a);
      send_word(vecs[i].b);
      wait_valid(lat);
      check("vec_latency",  32'(lat),      32'd2);
      check("vec_out_data", 32'(out_data), 32'(vecs[i].exp_c));
      check("vec_op_a",     32'(op_a),     32'(vecs[i].a));
      check("vec_op_b",     32'(op_b),     32'(vecs[i].b));
      check("vec_busy",     32'(busy),     32'd1);
      check("vec_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("vec_done_valid", 32'(out_valid),    32'd0);
      check("vec_done_count", 32'(result_count), 32'(i + 1));
      check("vec_done_ready", 32'(in_ready),     32'd1);
      @(posedge clk);
      #1;
    end

    // Back-pressure: 3*4 held for 10 cycles
    out_ready = 1'b0;
    send_word(12'd3);
    send_word(12'd4);
    wait_valid(lat);
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  32'(out_data),  32'd12);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_busy",      32'(busy),      32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid),    32'd0);
    check("bp_release_ready", 32'(in_ready),     32'd1);
    check("bp_release_count", 32'(result_count), 32'd7);
    @(posedge clk);
    #1;

    // Clear after a lone operand: 9 is discarded, then 2*6
    send_word(12'd9);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clr_in_ready", 32'(in_ready),     32'd1);
    check("clr_busy",     32'(busy),         32'd0);
    check("clr_count",    32'(result_count), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_word(12'd2);
    send_word(12'd6);
    wait_valid(lat);
    check("clr_out_data", 32'(out_data), 32'd12);
    check("clr_op_a",     32'(op_a),     32'd2);
    check("clr_op_b",     32'(op_b),     32'd6);
    @(negedge clk);
    check("clr_after_count", 32'(result_count), 32'd1);
    @(posedge clk);
    #1;

    // clear coincident with an output handshake: clear wins
    out_ready = 1'b0;
    send_word(12'd5);
    send_word(12'd5);
    wait_valid(lat);
    check("clrhs_out_data", 32'(out_data), 32'd25);
    out_ready = 1'b1;
    clear     = 1'b1;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("clrhs_count",     32'(result_count), 32'd0);
    check("clrhs_out_valid", 32'(out_valid),    32'd0);
    check("clrhs_out_data",  32'(out_data),     32'd25);

    // clear coincident with an input handshake: word dropped, stay in LOAD_A
    @(posedge clk);
    #1;
    in_data  = 12'd77;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    check("clrin_busy", 32'(busy), 32'd0);
    check("clrin_op_a", 32'(op_a), 32'd5);

    // Asynchronous reset while holding 35 in OUT
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_word(12'd5);
    send_word(12'd7);
    wait_valid(lat);
    check("rstmid_out_data_pre", 32'(out_data), 32'd35);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", 32'(out_valid),    32'd0);
    check("rstmid_out_data",  32'(out_data),     32'd0);
    check("rstmid_count",     32'(result_count), 32'd0);
    check("rstmid_op_a",      32'(op_a),         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    check("rstmid_busy",     32'(busy),     32'd0);

    // 256 back-to-back 1*1 products: wrap and 4-cycle throughput
    @(posedge clk);
    #1;
    in_data   = 12'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n        = 0;
    cyc      = 0;
    prev_cyc = 0;
    prev_cnt = result_count;
    while (n < 256 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (result_count != prev_cnt) begin
        n++;
        if (n == 255) check("wrap_count_255", 32'(result_count), 32'd255);
        else if (n == 256) check("wrap_count_0", 32'(result_count), 32'd0);
        else check("wrap_count", 32'(result_count), 32'(n));
        if (n >= 2) check("throughput_gap", 32'(cyc - prev_cyc), 32'd4);
        check("wrap_out_data", 32'(out_data), 32'd1);
        prev_cyc = cyc;
        prev_cnt = result_count;
      end
    end
    in_valid = 1'b0;
    check("wrap_results_seen", 32'(n), 32'd256);
    @(negedge clk);
    check("wrap_final_count", 32'(result_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
